// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO access controller: default widths and read-side state encoding.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts just after the last granted index.
// The pointer moves only on a grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] ptr
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % N);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        ptr_d    = idx;
        found    = 1'b1;
      end
    end
  end

  // Reset to the last index so requester 0 wins the first search.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PTR_W'(N - 1);
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_access_ctrl.sv
// Owns both ports of a shared synchronous FIFO.
// N_REQ producers are arbitrated onto the write port; popped words go to one valid/ready consumer.
module fifo_access_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int N_REQ    = 4,
  parameter int AF_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     fifo_w_en,
  output logic [WIDTH-1:0]         fifo_data_in,
  input  logic                     fifo_full,
  output logic                     fifo_r_en,
  input  logic [WIDTH-1:0]         fifo_data_out,
  input  logic                     fifo_empty,
  input  logic [CNT_W-1:0]         fifo_cnt,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     almost_full,
  output logic [1:0]               dbg_state,
  output logic [$clog2(N_REQ)-1:0] dbg_rr_ptr
);

  logic arb_en;

  // No bypass: a full FIFO blocks writes even when a pop happens in the same cycle.
  assign arb_en = !fifo_full && !rst;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (req),
    .gnt (gnt),
    .ptr (dbg_rr_ptr)
  );

  assign fifo_w_en = |gnt;

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) fifo_data_in = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Output handshake: a word transfers at a rising edge where out_valid and out_ready
  // are both 1. out_data is stable while out_valid=1 and out_ready=0.
  rd_state_e        state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             af_q, af_d;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    fifo_r_en   = 1'b0;
    af_d        = (fifo_cnt >= CNT_W'(AF_LEVEL));
    unique case (state_q)
      IDLE: begin
        fifo_r_en = !fifo_empty && !rst;
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        out_data_d  = fifo_data_out;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          fifo_r_en   = !fifo_empty && !rst;
          out_valid_d = 1'b0;
          state_d     = fifo_empty ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      af_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      af_q        <= af_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign almost_full = af_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Directed bench for fifo_access_ctrl driving a behavioural 8x8 registered-read FIFO.
module tb_fifo_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_w_en, fifo_r_en, fifo_full, fifo_empty;
  logic [7:0]  fifo_data_in, fifo_data_out;
  logic [3:0]  fifo_cnt;
  logic        out_valid, out_ready, almost_full;
  logic [7:0]  out_data;
  logic [1:0]  dbg_state, dbg_rr_ptr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_access_ctrl #(.WIDTH(8), .CNT_W(4), .N_REQ(4), .AF_LEVEL(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .fifo_w_en     (fifo_w_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_full     (fifo_full),
    .fifo_r_en     (fifo_r_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_cnt      (fifo_cnt),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .almost_full   (almost_full),
    .dbg_state     (dbg_state),
    .dbg_rr_ptr    (dbg_rr_ptr)
  );

  // Behavioural FIFO, DEPTH=8, data valid the cycle after r_en.
  logic [7:0] mem [8];
  logic [2:0] wp, rp;
  logic       do_w, do_r;

  assign fifo_full  = (fifo_cnt == 4'd8);
  assign fifo_empty = (fifo_cnt == 4'd0);
  assign do_w = fifo_w_en && !fifo_full;
  assign do_r = fifo_r_en && !fifo_empty;

  always @(posedge clk) begin
    if (rst) begin
      wp <= '0; rp <= '0; fifo_cnt <= '0; fifo_data_out <= '0;
    end else begin
      if (do_w) begin mem[wp] <= fifo_data_in; wp <= wp + 3'd1; end
      if (do_r) begin fifo_data_out <= mem[rp]; rp <= rp + 3'd1; end
      fifo_cnt <= fifo_cnt + {3'b0, do_w} - {3'b0, do_r};
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int idx, input logic [7:0] d);
    bit got = 1'b0;
    req = '0;
    req[idx] = 1'b1;
    req_data[idx*8 +: 8] = d;
    for (int c = 0; c < 20 && !got; c++) begin
      #2;
      if (gnt[idx]) begin
        got = 1'b1;
        chk("push_data", {24'b0, fifo_data_in}, {24'b0, d});
      end
      step();
    end
    chk("push_granted", {31'b0, got}, 32'd1);
    req = '0;
  endtask

  task automatic drain(input int budget);
    out_ready = 1'b1;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      #2;
      chk("r_en_while_empty", {31'b0, fifo_r_en & fifo_empty}, 32'd0);
      if (out_valid) chk("out_data_order", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
      step();
    end
    chk("drain_left", exp_q.size(), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 4'hF; req_data = 32'h44332211; out_ready = 1'b0;

    // Reset with all requests pending.
    for (int r = 0; r < 2; r++) begin
      step();
      #2;
      chk("rst_gnt", {28'b0, gnt}, 32'd0);
      chk("rst_w_en", {31'b0, fifo_w_en}, 32'd0);
      chk("rst_r_en", {31'b0, fifo_r_en}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    end
    rst = 1'b0;

    // Round robin until full: 9 words accepted (8 stored + 1 in HOLD).
    for (int k = 0; k < 9; k++) begin
      #2;
      chk("rr_gnt", {28'b0, gnt}, 32'(1 << (k % 4)));
      chk("rr_w_en", {31'b0, fifo_w_en}, 32'd1);
      chk("rr_data_in", {24'b0, fifo_data_in}, 32'(8'h11 * ((k % 4) + 1)));
      if (k == 0) chk("rr_r_en_empty", {31'b0, fifo_r_en}, 32'd0);
      if (k == 7) chk("af_lag_low", {31'b0, almost_full}, 32'd0);
      if (k == 8) chk("af_high", {31'b0, almost_full}, 32'd1);
      step();
    end
    #2;
    chk("full_flag", {31'b0, fifo_full}, 32'd1);
    chk("full_gnt", {28'b0, gnt}, 32'd0);
    chk("full_w_en", {31'b0, fifo_w_en}, 32'd0);
    chk("hold_valid", {31'b0, out_valid}, 32'd1);
    chk("hold_data", {24'b0, out_data}, 32'h11);

    // Full gating: requester 2 only after full drops, never in the pop cycle.
    req = 4'b0100;
    #1;
    chk("gate_gnt", {28'b0, gnt}, 32'd0);
    step();
    out_ready = 1'b1;
    #2;
    chk("pop_cycle_gnt", {28'b0, gnt}, 32'd0);
    chk("pop_cycle_r_en", {31'b0, fifo_r_en}, 32'd1);
    step();
    #2;
    chk("after_pop_full", {31'b0, fifo_full}, 32'd0);
    chk("after_pop_gnt", {28'b0, gnt}, 32'd4);
    chk("after_pop_data", {24'b0, fifo_data_in}, 32'h33);
    step();
    req = '0;
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h33};
    drain(40);

    // Ordering from a single requester.
    push_word(1, 8'h01);
    push_word(1, 8'h02);
    push_word(1, 8'h04);
    push_word(1, 8'h08);
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08};
    drain(30);

    // Backpressure with 0x8C held and six words queued.
    push_word(1, 8'h8C);
    for (int i = 1; i <= 6; i++) push_word(1, 8'(i));
    #2;
    chk("bp_cnt_e0", {28'b0, fifo_cnt}, 32'd6);
    chk("bp_af_e0", {31'b0, almost_full}, 32'd0);
    step();
    for (int c = 0; c < 5; c++) begin
      #2;
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_data", {24'b0, out_data}, 32'h8C);
      chk("bp_r_en", {31'b0, fifo_r_en}, 32'd0);
      chk("bp_cnt", {28'b0, fifo_cnt}, 32'd6);
      chk("bp_af", {31'b0, almost_full}, 32'd1);
      step();
    end
    exp_q = '{8'h8C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    drain(40);

    // Reset while a word is being fetched.
    push_word(1, 8'h5A);
    step();
    #2;
    chk("pre_rst_state", {30'b0, dbg_state}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    chk("mid_rst_state", {30'b0, dbg_state}, 32'd0);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_data", {24'b0, out_data}, 32'd0);
    chk("mid_rst_ptr", {30'b0, dbg_rr_ptr}, 32'd3);
    chk("mid_rst_cnt", {28'b0, fifo_cnt}, 32'd0);
    req = 4'hF;
    #1;
    chk("mid_rst_first_gnt", {28'b0, gnt}, 32'd1);
    req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
